// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the sequencer state encoding, default memory geometry and
// the bit positions that turn a PC byte address into a word address.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH    = 1024;
    localparam int unsigned IMEM_AW       = 10;

    // Word address is pc[IMEM_ADDR_MSB:IMEM_ADDR_LSB]; the low two bits select a byte.
    localparam int unsigned IMEM_ADDR_LSB = 2;
    localparam int unsigned IMEM_ADDR_MSB = IMEM_AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StRun
    } imem_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Bundle of the loader's control, byte-stream, fetch-address and memory-write signals.
// slave: the boot loader's view; master: the driver/observer's view.
interface imem_boot_loader_if
    import imem_pkg::*;
#(
    parameter int unsigned AW = IMEM_AW
);

    logic          start;
    logic [AW:0]   len_words;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [31:0]   pc_addr;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, len_words, byte_valid, byte_data, pc_addr,
        output byte_ready, mem_addr, mem_we, mem_wdata, cpu_hold, busy, done, err
    );

    modport master (
        output start, len_words, byte_valid, byte_data, pc_addr,
        input  byte_ready, mem_addr, mem_we, mem_wdata, cpu_hold, busy, done, err
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler.
// Byte k of a word lands in bits [8k+7:8k]; word_valid pulses for one cycle
// in the cycle after the fourth byte has been captured.
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic        valid_q;

    // Byte counter, in-place assembly register and the completed-word pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else if (clr) begin
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= byte_en && (cnt_q == 2'd3);
            if (byte_en) begin
                word_q[{cnt_q, 3'b000} +: 8] <= byte_data;
                cnt_q                        <= cnt_q + 2'd1;
            end
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: stalls the core, streams bytes into words
// written from address 0 upward, then returns the memory address to the PC.
// Optional inter-byte timeout is built only when IMEM_BOOT_TIMEOUT_EN is defined.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH   = IMEM_DEPTH,
    parameter int unsigned AW      = IMEM_AW,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_boot_loader_if.slave     bus
);

    localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);
    localparam logic [AW:0] OneLen   = (AW + 1)'(1);

    imem_state_e   state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          packer_clr;

    logic          start_ok, start_zero, start_bad;
    logic          xfer;
    logic          word_valid;
    logic [31:0]   word;
    logic          last_write;
    logic          tmo_hit;

    assign start_ok   = bus.start && (bus.len_words != '0) && (bus.len_words <= DepthLen);
    assign start_zero = bus.start && (bus.len_words == '0);
    assign start_bad  = bus.start && (bus.len_words > DepthLen);

    // Bytes are refused during the write cycle so one word costs at least five cycles.
    assign bus.byte_ready = (state_q == StLoad) && !word_valid;
    assign xfer           = bus.byte_valid && bus.byte_ready;
    assign bus.mem_we     = (state_q == StLoad) && word_valid;
    assign bus.mem_wdata  = word;
    assign last_write     = bus.mem_we && (({1'b0, ptr_q} + OneLen) == len_q);

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (packer_clr),
        .byte_en    (xfer),
        .byte_data  (bus.byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef IMEM_BOOT_TIMEOUT_EN
    logic [31:0] tmo_q;

    // Idle-cycle counter: runs only in LOAD and restarts on every accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 32'd0;
        end else if ((state_q != StLoad) || xfer) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end

    // A pending word write takes priority over abandoning the load.
    assign tmo_hit = (state_q == StLoad) && !xfer && !word_valid && (tmo_q == 32'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    // Next-state, pointer, length, error and done-pulse decisions.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        err_d      = err_q;
        done_d     = 1'b0;
        packer_clr = 1'b0;
        case (state_q)
            StIdle, StRun: begin
                if (start_ok) begin
                    state_d    = StLoad;
                    len_d      = bus.len_words;
                    ptr_d      = '0;
                    err_d      = 1'b0;
                    packer_clr = 1'b1;
                end else if (start_zero) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (start_bad) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StLoad: begin
                if (bus.mem_we) begin
                    // Pointer stays on the final word so it never wraps to 0 at full depth.
                    if (last_write) begin
                        state_d = StDrain;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d    = StIdle;
                    err_d      = 1'b1;
                    ptr_d      = '0;
                    packer_clr = 1'b1;
                end
            end
            StDrain: begin
                state_d = StRun;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // A start seen in RUN that leaves RUN raises the hold in that same cycle.
    assign bus.cpu_hold = (state_q != StRun) || (bus.start && (bus.len_words != '0));
    assign bus.busy     = (state_q == StLoad) || (state_q == StDrain);
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    // Fetch side addresses memory except while the loader owns it.
    assign bus.mem_addr = bus.busy ? ptr_q
                                   : bus.pc_addr[AW + IMEM_ADDR_LSB - 1 : IMEM_ADDR_LSB];

    logic unused_pc;
    assign unused_pc = ^{bus.pc_addr[31 : AW + IMEM_ADDR_LSB], bus.pc_addr[IMEM_ADDR_LSB - 1 : 0]};

endmodule
